// File: rtl/rvfpm_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rvfpm_result_arbiter
//  Purpose  : Round-robin arbiter sharing the XIF result channel between
//             NUM_REQ FPU writeback sources, with a one-entry registered
//             output stage and a saturating delivered-result counter.
//  Revision : 1.0 - initial release
// ============================================================================
module rvfpm_result_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*X_ID_WIDTH-1:0] req_id,
    input  logic [NUM_REQ*FLEN-1:0]       req_data,
    input  logic [NUM_REQ*5-1:0]          req_rd,
    input  logic [NUM_REQ-1:0]            req_we,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [X_ID_WIDTH-1:0]         result_id,
    output logic [FLEN-1:0]               result_data,
    output logic [4:0]                    result_rd,
    output logic                          result_we,
    output logic [$clog2(NUM_REQ)-1:0]    result_src,
    output logic [CNT_WIDTH-1:0]          result_count
);

    localparam int c_src_w  = $clog2(NUM_REQ);
    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int c_scan_w = c_src_w + 1;
    localparam logic [c_scan_w-1:0] c_num_req  = c_scan_w'(NUM_REQ);
    localparam logic [c_src_w-1:0]  c_last_idx = c_src_w'(NUM_REQ - 1);

    // Output stage and arbitration state
    logic                   r_valid;
    logic [X_ID_WIDTH-1:0]  r_id;
    logic [FLEN-1:0]        r_data;
    logic [4:0]             r_rd;
    logic                   r_we;
    logic [c_src_w-1:0]     r_src;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [c_src_w-1:0]     r_rr_ptr;

    // Per-requester views of the packed payload buses
    logic [X_ID_WIDTH-1:0]  w_id_arr   [NUM_REQ];
    logic [FLEN-1:0]        w_data_arr [NUM_REQ];
    logic [4:0]             w_rd_arr   [NUM_REQ];

    logic                   w_can_load;
    logic                   w_found;
    logic                   w_load;
    logic [c_scan_w-1:0]    w_scan;
    logic [c_src_w-1:0]     w_grant_idx;
    logic [c_src_w-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]     w_req_ready;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_id_arr[gi]   = req_id[gi*X_ID_WIDTH +: X_ID_WIDTH];
            assign w_data_arr[gi] = req_data[gi*FLEN +: FLEN];
            assign w_rd_arr[gi]   = req_rd[gi*5 +: 5];
        end
    endgenerate

    // Round-robin scan starting at rr_ptr; the slot may be refilled in the
    // same cycle the core accepts the current result (zero-bubble path).
    always_comb begin
        w_can_load  = ~r_valid | result_ready;
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + c_scan_w'(k);
            if (w_scan >= c_num_req) begin
                w_scan = w_scan - c_num_req;
            end
            if (!w_found && req_valid[w_scan[c_src_w-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan[c_src_w-1:0];
            end
        end
        w_load      = w_can_load & w_found;
        w_req_ready = '0;
        if (w_load) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
        w_next_ptr = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + 1'b1;
    end

    // Output register: load the winner, drain on handshake, otherwise hold.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_rd     <= '0;
            r_we     <= 1'b0;
            r_src    <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_id     <= w_id_arr[w_grant_idx];
            r_data   <= w_data_arr[w_grant_idx];
            r_rd     <= w_rd_arr[w_grant_idx];
            r_we     <= req_we[w_grant_idx];
            r_src    <= w_grant_idx;
            r_rr_ptr <= w_next_ptr;
        end else if (result_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // Saturating count of completed result handshakes.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_valid && result_ready && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign req_ready    = w_req_ready;
    assign result_valid = r_valid;
    assign result_id    = r_id;
    assign result_data  = r_data;
    assign result_rd    = r_rd;
    assign result_we    = r_we;
    assign result_src   = r_src;
    assign result_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_result_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvfpm_result_arbiter
//  Purpose  : Directed self-checking bench for rvfpm_result_arbiter
//             (NUM_REQ=3, CNT_WIDTH=4 so saturation is reachable quickly).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rvfpm_result_arbiter;

    localparam int NUM_REQ    = 3;
    localparam int X_ID_WIDTH = 4;
    localparam int FLEN       = 32;
    localparam int CNT_WIDTH  = 4;

    logic                          ck;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*X_ID_WIDTH-1:0] req_id;
    logic [NUM_REQ*FLEN-1:0]       req_data;
    logic [NUM_REQ*5-1:0]          req_rd;
    logic [NUM_REQ-1:0]            req_we;
    logic                          result_valid;
    logic                          result_ready;
    logic [X_ID_WIDTH-1:0]         result_id;
    logic [FLEN-1:0]               result_data;
    logic [4:0]                    result_rd;
    logic                          result_we;
    logic [1:0]                    result_src;
    logic [CNT_WIDTH-1:0]          result_count;

    int errors = 0;
    int checks = 0;

    rvfpm_result_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .X_ID_WIDTH(X_ID_WIDTH),
        .FLEN      (FLEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .ck          (ck),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_id      (req_id),
        .req_data    (req_data),
        .req_rd      (req_rd),
        .req_we      (req_we),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_id   (result_id),
        .result_data (result_data),
        .result_rd   (result_rd),
        .result_we   (result_we),
        .result_src  (result_src),
        .result_count(result_count)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] data,
                           input logic [4:0] rd, input logic we);
        req_id[i*X_ID_WIDTH +: X_ID_WIDTH] = id;
        req_data[i*FLEN +: FLEN]           = data;
        req_rd[i*5 +: 5]                   = rd;
        req_we[i]                          = we;
    endtask

    // Requester contract: a pending, ungranted request keeps valid and payload.
    logic [NUM_REQ-1:0]            p_valid, p_ready;
    logic [NUM_REQ*X_ID_WIDTH-1:0] p_id;
    logic [NUM_REQ*FLEN-1:0]       p_data;
    logic                          p_rst = 1'b0;
    always @(posedge ck) begin
        if (rst && p_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (p_valid[i] && !p_ready[i]) begin
                    chk("req_contract_valid", 64'(req_valid[i]), 64'd1);
                    chk("req_contract_id", 64'(req_id[i*X_ID_WIDTH +: X_ID_WIDTH]),
                        64'(p_id[i*X_ID_WIDTH +: X_ID_WIDTH]));
                    chk("req_contract_data", 64'(req_data[i*FLEN +: FLEN]),
                        64'(p_data[i*FLEN +: FLEN]));
                end
            end
        end
        p_valid = req_valid;
        p_ready = req_ready;
        p_id    = req_id;
        p_data  = req_data;
        p_rst   = rst;
    end

    initial begin
        rst          = 1'b0;
        req_valid    = '0;
        req_id       = '0;
        req_data     = '0;
        req_rd       = '0;
        req_we       = '0;
        result_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_count", 64'(result_count), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_id", 64'(result_id), 64'd0);
        chk("rst_data", 64'(result_data), 64'd0);
        chk("rst_src", 64'(result_src), 64'd0);
        rst = 1'b1;
        tick();

        // ---------------- single request ----------------
        set_req(1, 4'd7, 32'h3F80_0000, 5'd4, 1'b1);
        req_valid    = 3'b010;
        result_ready = 1'b1;
        #1;
        chk("single_grant", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        chk("single_valid", 64'(result_valid), 64'd1);
        chk("single_id", 64'(result_id), 64'd7);
        chk("single_data", 64'(result_data), 64'h3F80_0000);
        chk("single_rd", 64'(result_rd), 64'd4);
        chk("single_we", 64'(result_we), 64'd1);
        chk("single_src", 64'(result_src), 64'd1);
        tick();
        chk("single_drain", 64'(result_valid), 64'd0);
        chk("single_count", 64'(result_count), 64'd1);

        // ---------------- wrap and priority (rr_ptr is now 2) ----------------
        set_req(0, 4'd3, 32'h0000_0003, 5'd1, 1'b1);
        req_valid = 3'b001;
        #1;
        chk("wrap_grant0", 64'(req_ready), 64'b001);
        tick();
        set_req(0, 4'd9, 32'h0000_0009, 5'd2, 1'b0);
        set_req(1, 4'd10, 32'h0000_000A, 5'd3, 1'b1);
        req_valid = 3'b011;
        #1;
        chk("wrap_src0", 64'(result_src), 64'd0);
        chk("wrap_id3", 64'(result_id), 64'd3);
        chk("prio_grant1", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b001;
        chk("prio_src1", 64'(result_src), 64'd1);
        chk("prio_id10", 64'(result_id), 64'd10);
        chk("prio_count", 64'(result_count), 64'd2);
        #1;
        chk("prio_grant0", 64'(req_ready), 64'b001);
        tick();
        req_valid = 3'b000;
        chk("prio_id9", 64'(result_id), 64'd9);
        chk("prio_we0", 64'(result_we), 64'd0);
        tick();
        chk("prio_empty", 64'(result_valid), 64'd0);
        chk("prio_count4", 64'(result_count), 64'd4);

        // ---------------- asynchronous reset while FULL ----------------
        set_req(1, 4'd5, 32'h0000_0055, 5'd5, 1'b1);
        req_valid    = 3'b010;
        result_ready = 1'b0;
        tick();
        req_valid = 3'b000;
        chk("arst_pre_valid", 64'(result_valid), 64'd1);
        chk("arst_pre_id", 64'(result_id), 64'd5);
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(result_valid), 64'd0);
        chk("arst_id", 64'(result_id), 64'd0);
        chk("arst_data", 64'(result_data), 64'd0);
        chk("arst_src", 64'(result_src), 64'd0);
        chk("arst_count", 64'(result_count), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_idle", 64'(result_valid), 64'd0);

        // ---------------- round robin, rr_ptr back to 0 ----------------
        set_req(0, 4'd1, 32'h1111_1111, 5'd10, 1'b1);
        set_req(1, 4'd2, 32'h2222_2222, 5'd11, 1'b0);
        set_req(2, 4'd3, 32'h3333_3333, 5'd12, 1'b1);
        req_valid    = 3'b111;
        result_ready = 1'b1;
        #1;
        chk("rr_first_grant", 64'(req_ready), 64'b001);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_valid", 64'(result_valid), 64'd1);
            chk("rr_src", 64'(result_src), 64'(k % 3));
            chk("rr_id", 64'(result_id), 64'((k % 3) + 1));
            chk("rr_we", 64'(result_we), 64'((k % 3) != 1));
            chk("rr_count", 64'(result_count), 64'(k));
        end
        tick();
        // seventh result (src 0) is now held; six handshakes are complete
        chk("rr_count6", 64'(result_count), 64'd6);
        chk("rr_src_wrap", 64'(result_src), 64'd0);

        // ---------------- backpressure ----------------
        req_valid    = 3'b110;
        result_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
            chk("bp_valid", 64'(result_valid), 64'd1);
            chk("bp_src", 64'(result_src), 64'd0);
            chk("bp_id", 64'(result_id), 64'd1);
            chk("bp_data", 64'(result_data), 64'h1111_1111);
            chk("bp_count", 64'(result_count), 64'd6);
        end
        result_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'b010);
        tick();
        chk("bp_src1", 64'(result_src), 64'd1);
        chk("bp_id2", 64'(result_id), 64'd2);
        chk("bp_count7", 64'(result_count), 64'd7);

        // ---------------- counter saturation ----------------
        rst       = 1'b0;
        req_valid = 3'b000;
        tick();
        rst = 1'b1;
        set_req(0, 4'd6, 32'h6666_6666, 5'd6, 1'b1);
        req_valid    = 3'b001;
        result_ready = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 15) chk("sat_count14", 64'(result_count), 64'd14);
            if (n == 16) chk("sat_count15", 64'(result_count), 64'd15);
            if (n == 21) chk("sat_count20hs", 64'(result_count), 64'd15);
        end
        chk("sat_hold", 64'(result_count), 64'd15);
        chk("sat_src", 64'(result_src), 64'd0);

        rst       = 1'b0;
        req_valid = 3'b000;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvfpm_result_arbiter.md
Name: rvfpm_result_arbiter

Overview:
- Shares the single CORE-V-XIF result channel of the FPU coprocessor between NUM_REQ internal writeback sources, e.g. the arithmetic pipeline, the load-completion path and the compare/convert unit.
- Selects one pending source per cycle with a round-robin grant and registers the winning result into a one-entry output stage.
- Holds result_valid and the payload stable until result_ready, while sustaining one result per cycle when the core does not backpressure.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- X_ID_WIDTH, 4, XIF instruction id width.
- FLEN, 32, result data width.
- CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
- ck  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  requester i has a result pending.
- req_ready  output  NUM_REQ  one-hot grant; requester i's result taken this cycle.
- req_id  input  NUM_REQ*X_ID_WIDTH  packed ids, slice i belongs to requester i.
- req_data  input  NUM_REQ*FLEN  packed result data.
- req_rd  input  NUM_REQ*5  packed destination register indices.
- req_we  input  NUM_REQ  register-write enable per requester.
- result_valid  output  1  XIF result valid.
- result_ready  input  1  XIF result ready from core.
- result_id  output  X_ID_WIDTH  registered id.
- result_data  output  FLEN  registered data.
- result_rd  output  5  registered rd.
- result_we  output  1  registered we.
- result_src  output  $clog2(NUM_REQ)  index of the source that produced the current result.
- result_count  output  CNT_WIDTH  saturating count of completed result handshakes.

Behaviour:
- Clock and reset: one clock ck; reset rst is asynchronous and active-low.
- Reset values: result_valid=0, result_id/data/rd/we/src=0, result_count=0, rr_ptr=0, req_ready=0.
- State (implicit in result_valid):
  - EMPTY (result_valid=0).
  - FULL (result_valid=1).
- can_load = !result_valid | result_ready. This is a combinational path from result_ready to req_ready, and it is intended.
- Arbitration (combinational):
  - When can_load=1, grant the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready is one-hot on the granted bit, else all 0.
  - When can_load=0, req_ready is all 0.
- Load: on a grant, the output register captures the slices of the granted requester and sets result_src=i and result_valid=1. rr_ptr becomes (i+1) mod NUM_REQ; at i=NUM_REQ-1 it wraps to 0.
- No grant:
  - rr_ptr is unchanged.
  - If result_ready=1 while FULL, result_valid clears to 0 (FULL->EMPTY).
  - Payload registers keep their old values.
- FULL with result_ready=0:
  - All outputs are held bit-stable.
  - No grant is issued.
  - rr_ptr is unchanged.
- FULL with result_ready=1 and a pending request: the handshake completes and the next result loads in the same cycle (FULL->FULL), giving zero-bubble back-to-back delivery.
- Latency: a request granted in cycle N appears on result_* in cycle N+1.
- Requester contract:
  - Once asserted, req_valid and its payload stay stable until req_ready.
  - The arbiter does not check this; the bench asserts it.
- Fairness: with all requesters continuously valid and result_ready=1, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 handshakes.
- result_count increments on each cycle where result_valid & result_ready, and saturates at all-ones.
- Simultaneous handshake and reset: asynchronous reset wins. An in-flight result is dropped and requesters see no ready. Requesters are reset by the same rst.
- req_we=0 results are arbitrated and delivered like any other result.

Test Plan:
- Reset: assert rst=0 mid-FULL with result_valid=1, id=5 -> all outputs 0 immediately (asynchronous), count=0, rr_ptr=0; after release with no requests, result_valid stays 0.
- Single request: req_valid=3'b010, id=7, data=32'h3F800000, rd=4, result_ready=1 -> req_ready=3'b010 in cycle N; in cycle N+1 result_valid=1, id=7, data=3F800000, rd=4, src=1; one cycle later result_valid=0 and count=1.
- Round-robin: all three valid continuously, result_ready=1 for 6 cycles -> src sequence 0,1,2,0,1,2, one result per cycle, count=6.
- Backpressure: FULL with src=0, result_ready=0 for 4 cycles while req 1 and req 2 are valid -> outputs stable and req_ready=0 throughout; on result_ready=1, req 1 is granted in the same cycle and src=1 on the next cycle.
- Wrap and priority: rr_ptr=2, req_valid=3'b001 -> grant requester 0 and rr_ptr becomes 1; then req_valid=3'b011 -> grant requester 1.
- Counter saturation: with CNT_WIDTH=4, perform 20 handshakes -> result_count=15 and stays there.
